// File: rtl/master_bridge_axi_write_sequencer.sv
// ---------------------------------------------------------------------------
// master_bridge_axi_write_sequencer
//
// Purpose:
//   Turns queued AXI4 write requests into AXI write traffic on the AXI clock
//   side of the master bridge. It takes one address word from the AW FIFO and
//   drives the AW handshake. It then streams AWLEN+1 data beats out of the W
//   FIFO and marks the final beat with WLAST. The B channel is forwarded into
//   the B FIFO. An outstanding-write counter stops new AW issue once
//   MAX_OUTSTANDING writes are waiting for their response.
//
// Ports:
//   i_axi_clk / i_axi_n_rst   AXI clock, asynchronous active-low reset
//   i_AWVALID_fifo            AW FIFO holds an entry (show-ahead head valid)
//   i_AW_CHANNEL_fifo         AW FIFO head word
//   o_aw_ch_read_inc          AW FIFO pop pulse
//   i_WVALID_fifo             W FIFO holds an entry
//   i_W_CHANNEL_fifo          W FIFO head word
//   o_w_ch_read_inc           W FIFO pop pulse
//   o_AWVALID / i_AWREADY     AXI AW handshake
//   o_AW_CHANNEL              registered AW payload
//   o_WVALID / i_WREADY       AXI W handshake
//   o_W_CHANNEL / o_WLAST     W payload (FIFO head passthrough) and last flag
//   i_BVALID / o_BREADY       AXI B handshake
//   i_B_CHANNEL               AXI B payload
//   i_b_fifo_full             B FIFO full flag
//   o_b_ch_write_inc          B FIFO push pulse
//   o_B_CHANNEL               B FIFO write data
//   o_outstanding_cnt         writes issued whose B has not yet returned
//   o_unexpected_b            sticky: a B was accepted while the counter was 0
//   o_busy                    sequencer is not idle
// ---------------------------------------------------------------------------
module master_bridge_axi_write_sequencer #(
  parameter int Ax_CHANNEL_WIDTH  = 100,
  parameter int W_CHANNEL_WIDTH   = 1152,
  parameter int B_CHANNEL_WIDTH   = 31,
  parameter int AxLEN_LSB         = 18,
  parameter int AxLEN_FIELD_WIDTH = 8,
  parameter int MAX_OUTSTANDING   = 8,
  parameter int OUTST_CNT_WIDTH   = 4
) (
  input  logic                          i_axi_clk,
  input  logic                          i_axi_n_rst,
  input  logic                          i_AWVALID_fifo,
  input  logic [Ax_CHANNEL_WIDTH-1:0]   i_AW_CHANNEL_fifo,
  output logic                          o_aw_ch_read_inc,
  input  logic                          i_WVALID_fifo,
  input  logic [W_CHANNEL_WIDTH-1:0]    i_W_CHANNEL_fifo,
  output logic                          o_w_ch_read_inc,
  output logic                          o_AWVALID,
  output logic [Ax_CHANNEL_WIDTH-1:0]   o_AW_CHANNEL,
  input  logic                          i_AWREADY,
  output logic                          o_WVALID,
  output logic [W_CHANNEL_WIDTH-1:0]    o_W_CHANNEL,
  output logic                          o_WLAST,
  input  logic                          i_WREADY,
  input  logic                          i_BVALID,
  input  logic [B_CHANNEL_WIDTH-1:0]    i_B_CHANNEL,
  output logic                          o_BREADY,
  input  logic                          i_b_fifo_full,
  output logic                          o_b_ch_write_inc,
  output logic [B_CHANNEL_WIDTH-1:0]    o_B_CHANNEL,
  output logic [OUTST_CNT_WIDTH-1:0]    o_outstanding_cnt,
  output logic                          o_unexpected_b,
  output logic                          o_busy
);

  localparam logic [OUTST_CNT_WIDTH-1:0] MAX_CNT = OUTST_CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [OUTST_CNT_WIDTH-1:0] CNT_ONE = OUTST_CNT_WIDTH'(1);
  localparam logic [AxLEN_FIELD_WIDTH-1:0] BEAT_ONE = AxLEN_FIELD_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [Ax_CHANNEL_WIDTH-1:0]    aw_q, aw_d;
  logic [AxLEN_FIELD_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OUTST_CNT_WIDTH-1:0]     outst_q, outst_d;
  logic                           unexp_q, unexp_d;

  logic can_issue;
  logic aw_hs;
  logic b_hs;

  // A new write may start only while fewer than MAX_OUTSTANDING are in flight.
  // The counter rises only on an AW handshake, which follows an IDLE check of
  // this condition, so the counter can never go past the limit.
  assign can_issue = (outst_q < MAX_CNT);

  // Sequencer state and registered AW payload / remaining-beat counter.
  always_ff @(posedge i_axi_clk or negedge i_axi_n_rst) begin
    if (!i_axi_n_rst) begin
      state_q    <= ST_IDLE;
      aw_q       <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      aw_q       <= aw_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state and handshake outputs. beat_cnt holds the number of beats
  // still to send after the current one, so a beat with beat_cnt==0 is WLAST.
  // The AW pop is gated by reset so no FIFO entry is lost while the bridge
  // is held in reset.
  always_comb begin
    state_d          = state_q;
    aw_d             = aw_q;
    beat_cnt_d       = beat_cnt_q;
    o_aw_ch_read_inc = 1'b0;
    o_AWVALID        = 1'b0;
    o_WVALID         = 1'b0;
    o_WLAST          = 1'b0;
    o_w_ch_read_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_AWVALID_fifo && can_issue && i_axi_n_rst) begin
          aw_d             = i_AW_CHANNEL_fifo;
          beat_cnt_d       = i_AW_CHANNEL_fifo[AxLEN_LSB +: AxLEN_FIELD_WIDTH];
          o_aw_ch_read_inc = 1'b1;
          state_d          = ST_ADDR;
        end
      end

      ST_ADDR: begin
        o_AWVALID = 1'b1;
        if (i_AWREADY) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        // An empty W FIFO inserts a bubble. The FIFO cannot become empty
        // again without a pop, so WVALID never drops once it is presented.
        o_WVALID = i_WVALID_fifo;
        o_WLAST  = i_WVALID_fifo && (beat_cnt_q == '0);
        if (i_WVALID_fifo && i_WREADY) begin
          o_w_ch_read_inc = 1'b1;
          if (beat_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - BEAT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_AW_CHANNEL = aw_q;
  assign o_W_CHANNEL  = i_W_CHANNEL_fifo;
  assign o_busy       = (state_q != ST_IDLE);

  // The B path does not depend on the sequencer. Responses flow straight
  // into the B FIFO whenever it has room.
  assign o_BREADY         = ~i_b_fifo_full;
  assign o_b_ch_write_inc = i_BVALID & ~i_b_fifo_full;
  assign o_B_CHANNEL      = i_B_CHANNEL;

  assign aw_hs = o_AWVALID & i_AWREADY;
  assign b_hs  = o_b_ch_write_inc;

  // Outstanding-write bookkeeping. An issue and a response in the same cycle
  // cancel out. A response with nothing outstanding is a protocol error. It
  // is flagged stickily, and the counter stays at zero instead of wrapping.
  always_comb begin
    outst_d = outst_q;
    unexp_d = unexp_q;

    if (b_hs && (outst_q == '0)) begin
      unexp_d = 1'b1;
    end

    case ({aw_hs, b_hs})
      2'b10: outst_d = outst_q + CNT_ONE;
      2'b01: begin
        if (outst_q != '0) begin
          outst_d = outst_q - CNT_ONE;
        end
      end
      default: outst_d = outst_q;
    endcase
  end

  // Outstanding counter and unexpected-response flag. Only reset clears
  // the flag.
  always_ff @(posedge i_axi_clk or negedge i_axi_n_rst) begin
    if (!i_axi_n_rst) begin
      outst_q <= '0;
      unexp_q <= 1'b0;
    end else begin
      outst_q <= outst_d;
      unexp_q <= unexp_d;
    end
  end

  assign o_outstanding_cnt = outst_q;
  assign o_unexpected_b    = unexp_q;

endmodule
